// File: rtl/uart_program_loader.sv
// Loads 24-bit instructions from a UART byte stream into instruction memory,
// framed by start word 0x0000FF and stop word 0x00F0FF, then pulses CPU reset.
module uart_program_loader #(
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int RST_PULSE      = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [23:0]       o_imem_wdata,
  output logic              o_loading,
  output logic              o_cpu_rst,
  output logic              o_load_done,
  output logic [ADDR_W:0]   o_word_count,
  output logic              o_err_overflow,
  output logic [1:0]        o_dbg_state
);

  // Handshake: i_rx_valid is a one-cycle strobe with no ready; every strobe
  // seen in IDLE or LOAD is consumed that cycle, strobes in RESET_OUT are dropped.

  localparam logic [23:0]       START_WORD = 24'h0000FF;
  localparam logic [23:0]       STOP_WORD  = 24'h00F0FF;
  localparam int                TO_W       = $clog2(TIMEOUT_CYCLES + 1);
  localparam int                PL_W       = $clog2(RST_PULSE + 1);
  localparam logic [TO_W-1:0]   TO_MAX     = TO_W'(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0]   TO_ONE     = TO_W'(1);
  localparam logic [PL_W-1:0]   PL_LAST    = PL_W'(RST_PULSE - 1);
  localparam logic [PL_W-1:0]   PL_ONE     = PL_W'(1);
  localparam logic [ADDR_W:0]   DEPTH      = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOAD      = 2'd1,
    S_RESET_OUT = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [23:0]       r_sr;
  logic [1:0]        r_byte_cnt;
  logic [TO_W-1:0]   r_timeout;
  logic [PL_W-1:0]   r_pulse;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_count;
  logic              r_we;
  logic [23:0]       r_wdata;
  logic              r_done;
  logic              r_err;

  logic              w_timed_out;
  logic [23:0]       w_sr_base;
  logic [23:0]       w_sr_shift;
  logic [1:0]        w_byte_idx;
  logic              w_shift;
  logic              w_enter_load;
  logic              w_stop;
  logic              w_write;
  logic              w_overflow;

  // A saturated idle counter means any partial word / hunt history is stale.
  assign w_timed_out = (r_timeout == TO_MAX);
  assign w_sr_base   = w_timed_out ? 24'h0 : r_sr;
  assign w_sr_shift  = {w_sr_base[15:0], i_rx_data};
  assign w_byte_idx  = w_timed_out ? 2'd0 : r_byte_cnt;

  always_comb begin
    w_state_nxt  = r_state;
    w_shift      = 1'b0;
    w_enter_load = 1'b0;
    w_stop       = 1'b0;
    w_write      = 1'b0;
    w_overflow   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_rx_valid) begin
          w_shift = 1'b1;
          if (w_sr_shift == START_WORD) begin
            w_enter_load = 1'b1;
            w_state_nxt  = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (i_rx_valid) begin
          w_shift = 1'b1;
          if (w_byte_idx == 2'd2) begin
            if (w_sr_shift == STOP_WORD) begin
              w_stop      = 1'b1;
              w_state_nxt = S_RESET_OUT;
            end else if (w_sr_shift == START_WORD) begin
              w_enter_load = 1'b1;
            end else if (r_count < DEPTH) begin
              w_write = 1'b1;
            end else begin
              w_overflow = 1'b1;
            end
          end
        end
      end
      S_RESET_OUT: begin
        if (r_pulse == PL_LAST) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_sr       <= '0;
      r_byte_cnt <= '0;
      r_timeout  <= '0;
      r_pulse    <= '0;
      r_addr     <= '0;
      r_count    <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_timeout <= i_rx_valid ? '0 : (w_timed_out ? r_timeout : r_timeout + TO_ONE);

      if (w_shift)          r_sr <= w_sr_shift;
      else if (w_timed_out) r_sr <= '0;

      if (w_enter_load || w_stop)
        r_byte_cnt <= 2'd0;
      else if (w_shift && r_state == S_LOAD)
        r_byte_cnt <= (w_byte_idx == 2'd2) ? 2'd0 : w_byte_idx + 2'd1;
      else if (w_timed_out)
        r_byte_cnt <= 2'd0;

      r_we   <= w_write;
      r_done <= w_stop;
      if (w_write) r_wdata <= w_sr_shift;

      // Address and count advance after the write cycle has presented them.
      if (w_enter_load) begin
        r_addr  <= '0;
        r_count <= '0;
        r_err   <= 1'b0;
      end else begin
        if (r_we) begin
          r_addr  <= r_addr + ADDR_ONE;
          r_count <= r_count + CNT_ONE;
        end
        if (w_overflow) r_err <= 1'b1;
      end

      r_pulse <= (r_state == S_RESET_OUT) ? r_pulse + PL_ONE : '0;
    end
  end

  assign o_imem_we      = r_we;
  assign o_imem_addr    = r_addr;
  assign o_imem_wdata   = r_wdata;
  assign o_loading      = (r_state != S_IDLE);
  assign o_cpu_rst      = (r_state == S_RESET_OUT);
  assign o_load_done    = r_done;
  assign o_word_count   = r_count;
  assign o_err_overflow = r_err;
  assign o_dbg_state    = r_state;

endmodule
